// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - FSM state encoding and default parameters for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester strictly after the last grant
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last_grant,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    // Walk offsets 1..N_REQ so the last grantee is considered only after everyone else.
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = IW'((int'(i_last_grant) + i) % N_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-requester single-outstanding memory port arbiter; MEM_ARB_TIMEOUT_EN adds a WAIT timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_we,
  input  logic [N_REQ-1:0][AW-1:0] req_addr,
  input  logic [N_REQ-1:0][DW-1:0] req_wdata,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DW-1:0]          rsp_rdata,
  output logic                   rsp_err,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_rsp_valid,
  input  logic [DW-1:0]          mem_rdata
);

  localparam int IW = $clog2(N_REQ);

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_last_grant;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_gidx;
  logic             w_any;
  logic             w_accept;
  logic             w_rsp_done;
  logic             w_expire;
  logic [N_REQ-1:0] w_owner_oh;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_rr (
    .i_req       (req_valid),
    .i_last_grant(r_last_grant),
    .o_grant     (w_grant),
    .o_idx       (w_gidx),
    .o_any       (w_any)
  );

  // The cycle that presents a response is not an accept cycle, so back-to-back
  // transactions are spaced by at least four cycles.
  assign w_accept   = (r_state == ST_IDLE) && w_any && (r_rsp_valid == '0) && !rst;
  assign w_rsp_done = (r_state == ST_WAIT) && mem_rsp_valid;
  assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_last_grant;

  assign req_ready = w_accept ? w_grant : '0;
  assign mem_valid = (r_state == ST_ISSUE);
  assign mem_we    = mem_valid & r_we;
  assign mem_addr  = mem_valid ? r_addr : '0;
  assign mem_wdata = mem_valid ? r_wdata : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE: if (mem_ready) w_next = ST_WAIT;
      ST_WAIT:  if (w_rsp_done || w_expire) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // last_grant doubles as the owner of the outstanding transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IW'(N_REQ - 1);
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_gidx;
      r_we         <= req_we[w_gidx];
      r_addr       <= req_addr[w_gidx];
      r_wdata      <= req_wdata[w_gidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      if (w_rsp_done) begin
        r_rsp_valid <= w_owner_oh;
        r_rsp_rdata <= mem_rdata;
      end else if (w_expire) begin
        r_rsp_valid <= w_owner_oh;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_rsp_err;

  // A response arriving on the expiry cycle takes precedence.
  assign w_expire = (r_state == ST_WAIT) && !mem_rsp_valid && (r_cnt == CW'(TIMEOUT - 1));
  assign rsp_err  = r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_expire;
      if ((r_state == ST_WAIT) && !w_rsp_done && !w_expire) r_cnt <= r_cnt + 1'b1;
      else                                                 r_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT;
  assign w_expire         = 1'b0;
  assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (vector table, scoreboard, corner sequences)
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        req_we;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0]        rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic                mem_valid;
  logic                mem_ready;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_rsp_valid;
  logic [DW-1:0]       mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_idx;
  } vec_t;

  rsp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          last_rsp_cyc = 0;
  int          rsp_count = 0;
  int          hs_count = 0;
  int          rsp_cnt = -1;
  int          rsp_delay = 0;
  int          idle_bad = 0;
  bit          auto_rsp = 1'b1;
  bit          force_rsp = 1'b0;
  logic [31:0] model_rdata = '0;

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endfunction

  function automatic void push_exp(input int idx, input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.idx = idx; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endfunction

  // One clock: memory model drives after the edge, monitor samples 1ns later.
  task automatic tick();
    bit   hs;
    rsp_t e;
    hs = mem_valid && mem_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      hs_count++;
      if (auto_rsp) rsp_cnt = rsp_delay;
    end
    mem_rsp_valid = force_rsp;
    if (rsp_cnt == 0) begin
      mem_rsp_valid = 1'b1;
      rsp_cnt = -1;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
    end
    mem_rdata = mem_rsp_valid ? model_rdata : 32'hBAD0_BAD0;
    #1;
    if (rsp_valid != '0) begin
      rsp_count++;
      last_rsp_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 4'b0001 << e.idx);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end else if (rsp_rdata != '0 || rsp_err != 1'b0) begin
      idle_bad++;
    end
  endtask

  task automatic wait_ready(input int budget, output int idx, output bit ok);
    ok = 1'b0;
    idx = 99;
    #1;
    for (int k = 0; k < budget; k++) begin
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
      #1;
    end
    if (ok) for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; mem_ready = 1'b1;
    force_rsp = 1'b0; auto_rsp = 1'b1; rsp_cnt = -1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    int   ord[6];
    int   idx, acc, prev, rc, hs0;
    bit   ok, stable;

    vt[0] = '{4'b0100, 4'b0000, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 2};
    vt[1] = '{4'b1111, 4'b0000, 32'h0000_0200, 32'h0000_0000, 32'h1111_2222, 3};
    vt[2] = '{4'b1111, 4'b0001, 32'h0000_0304, 32'hA5A5_0001, 32'h3333_4444, 0};
    vt[3] = '{4'b0011, 4'b0000, 32'h0000_0408, 32'h0000_0000, 32'h5555_6666, 1};
    vt[4] = '{4'b0001, 4'b0000, 32'h0000_050C, 32'h0000_0000, 32'h7777_8888, 0};
    vt[5] = '{4'b1000, 4'b1000, 32'h0000_0610, 32'h1234_5678, 32'h0000_0000, 3};
    vt[6] = '{4'b0110, 4'b0000, 32'h0000_0714, 32'h0000_0000, 32'h9999_AAAA, 1};
    vt[7] = '{4'b1101, 4'b0100, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'hBBBB_CCCC, 2};
    ord   = '{0, 1, 2, 3, 0, 1};

    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;

    rst = 1'b1;
    tick();
    chk("rst_rsp", {req_ready, rsp_valid, rsp_rdata, rsp_err}, 0);
    chk("rst_mem", {mem_valid, mem_we, mem_addr, mem_wdata}, 0);
    do_reset();

    // Table-driven single transactions with round-robin expectations.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) begin
        req_addr[i]  = vt[v].addr  ^ (32'(i) << 16) ^ (32'(vt[v].exp_idx) << 16);
        req_wdata[i] = vt[v].wdata ^ (32'(i) << 24) ^ (32'(vt[v].exp_idx) << 24);
      end
      req_we = vt[v].we;
      req_valid = vt[v].valid;
      wait_ready(8, idx, ok);
      chk("vec_ready", req_ready, 4'b0001 << vt[v].exp_idx);
      acc = cyc;
      model_rdata = vt[v].rdata;
      push_exp(vt[v].exp_idx, vt[v].rdata, 1'b0);
      tick();
      req_valid = '0;
      #1;
      chk("vec_mem_valid", mem_valid, 1);
      chk("vec_mem_addr", mem_addr, vt[v].addr);
      chk("vec_mem_we", mem_we, vt[v].we[vt[v].exp_idx]);
      chk("vec_mem_wdata", mem_wdata, vt[v].wdata);
      drain(10);
      chk("vec_latency", last_rsp_cyc - acc, 3);
    end

    // Fairness with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i] = 32'h40 * i;
    req_we = '0;
    req_valid = 4'b1111;
    prev = 0;
    for (int g = 0; g < 6; g++) begin
      wait_ready(10, idx, ok);
      chk("fair_grant", idx, ord[g]);
      if (g > 0) chk("fair_spacing", cyc - prev, 4);
      prev = cyc;
      model_rdata = 32'h1000 + g;
      push_exp(ord[g], 32'h1000 + g, 1'b0);
      tick();
    end
    req_valid = '0;
    drain(10);

    // Backpressure with stray responses during ISSUE.
    mem_ready = 1'b0;
    req_we = 4'b0010;
    req_addr[1] = 32'h0000_2000;
    req_wdata[1] = 32'h55AA_55AA;
    req_valid = 4'b0010;
    wait_ready(8, idx, ok);
    chk("bp_ready", req_ready, 4'b0010);
    push_exp(1, 32'h0000_0077, 1'b0);
    model_rdata = 32'h0000_0BAD;
    hs0 = hs_count;
    tick();
    req_valid = '0;
    #1;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(mem_valid && mem_we && mem_addr == 32'h0000_2000 && mem_wdata == 32'h55AA_55AA)) stable = 1'b0;
      force_rsp = (k == 1 || k == 2);
      tick();
      #1;
    end
    force_rsp = 1'b0;
    chk("bp_stable", stable, 1);
    chk("bp_no_early_rsp", sb.size(), 1);
    model_rdata = 32'h0000_0077;
    mem_ready = 1'b1;
    tick();
    drain(10);
    chk("bp_single_issue", hs_count - hs0, 1);

    // Stray response while idle.
    rc = rsp_count;
    force_rsp = 1'b1;
    tick(); tick();
    force_rsp = 1'b0;
    tick(); tick();
    chk("stray_idle", rsp_count - rc, 0);

    // Missing memory response.
    auto_rsp = 1'b0;
    req_we = '0;
    req_addr[2] = 32'h0000_3000;
    req_valid = 4'b0100;
    wait_ready(8, idx, ok);
    chk("to_ready", req_ready, 4'b0100);
    acc = cyc;
    tick();
    req_valid = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    push_exp(2, 32'h0, 1'b1);
    drain(40);
    chk("timeout_latency", last_rsp_cyc - acc, 2 + TO);
    rc = rsp_count;
    model_rdata = 32'h0BAD_0BAD;
    force_rsp = 1'b1;
    tick();
    force_rsp = 1'b0;
    tick(); tick();
    chk("late_rsp_ignored", rsp_count - rc, 0);
`else
    rc = rsp_count;
    repeat (30) tick();
    chk("wait_indefinite", rsp_count - rc, 0);
    model_rdata = 32'hCAFE_0001;
    push_exp(2, 32'hCAFE_0001, 1'b0);
    force_rsp = 1'b1;
    tick();
    force_rsp = 1'b0;
    drain(5);
    chk("late_rsp_taken", rsp_count - rc, 1);
`endif
    auto_rsp = 1'b1;

    // Reset while waiting for the memory.
    auto_rsp = 1'b0;
    req_valid = 4'b1000;
    wait_ready(8, idx, ok);
    chk("rw_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rw_rsp_zero", {rsp_valid, rsp_rdata, rsp_err}, 0);
    chk("rw_mem_zero", {mem_valid, mem_we, mem_addr, mem_wdata}, 0);
    req_valid = 4'b1111;
    #1;
    chk("rw_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    req_valid = '0;
    rc = rsp_count;
    force_rsp = 1'b1;
    tick();
    force_rsp = 1'b0;
    tick();
    chk("rw_stray", rsp_count - rc, 0);
    auto_rsp = 1'b1;
    req_valid = 4'b1111;
    wait_ready(8, idx, ok);
    chk("rw_first_grant", req_ready, 4'b0001);
    model_rdata = 32'h5150_0000;
    push_exp(0, 32'h5150_0000, 1'b0);
    tick();
    req_valid = '0;
    drain(10);

    chk("idle_rsp_zero", idle_bad, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
